// File: rtl/life_pkg.sv
// Shared definitions for the life-array read path: quadrant selectors,
// the cell-to-quadrant-bit mapping, and the reader state encoding.
package life_pkg;

  localparam logic [1:0] QUAD_TL = 2'b00;
  localparam logic [1:0] QUAD_BL = 2'b01;
  localparam logic [1:0] QUAD_TR = 2'b10;
  localparam logic [1:0] QUAD_BR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_SELECT,
    ST_WAIT,
    ST_CAPTURE,
    ST_EMIT,
    ST_DONE
  } state_e;

  // Quadrant holding global cell (r,c): column half in the MSB, row half in the LSB.
  function automatic logic [1:0] cell_quad(input logic [2:0] r, input logic [2:0] c);
    return {c[2], r[2]};
  endfunction

  // Bit position of global cell (r,c) inside its quadrant word.
  function automatic logic [3:0] cell_bit(input logic [2:0] r, input logic [2:0] c);
    return {c[1:0], r[1:0]};
  endfunction

endpackage

// File: rtl/life_frame_buffer.sv
// 64-cell frame store written one 16-bit quadrant at a time and read one row
// at a time. The row port sees the store including a same-cycle write.
module life_frame_buffer
  import life_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [1:0]  wr_quad_i,
  input  logic [15:0] wr_data_i,
  input  logic [2:0]  rd_row_i,
  output logic [7:0]  rd_data_o
);

  logic [3:0][15:0] quad_q, quad_d;

  always_comb begin
    quad_d = quad_q;
    if (wr_en_i) quad_d[wr_quad_i] = wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) quad_q <= '0;
    else       quad_q <= quad_d;
  end

  // Write-through read so the first row can be registered on the final capture edge.
  always_comb begin
    rd_data_o = '0;
    for (int c = 0; c < 8; c++) begin
      rd_data_o[c] = quad_d[cell_quad(rd_row_i, 3'(c))][cell_bit(rd_row_i, 3'(c))];
    end
  end

endmodule

// File: rtl/life_array_reader.sv
// Read-side controller for the 8x8 life array: optional generation step,
// four-quadrant capture into a frame buffer, then row streaming over valid/ready.
module life_array_reader
  import life_pkg::*;
#(
  parameter int unsigned SAMPLE_WAIT = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        advance_i,
  input  logic [15:0] valo_i,
  output logic [1:0]  valo_selector_o,
  output logic        step_o,
  output logic [7:0]  row_data_o,
  output logic [2:0]  row_index_o,
  output logic        row_valid_o,
  input  logic        row_ready_i,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam logic [1:0] WAIT_INIT = (SAMPLE_WAIT == 0) ? 2'd0 : 2'(SAMPLE_WAIT - 1);

  state_e      state_q, state_d;
  logic [1:0]  quad_q, quad_d;
  logic [1:0]  wait_q, wait_d;
  logic [2:0]  row_q, row_d;
  logic        wr_en;
  logic [7:0]  rd_data;

  logic [1:0]  sel_q;
  logic        step_q;
  logic [7:0]  row_data_q;
  logic        row_valid_q;
  logic        busy_q;
  logic        frame_done_q;

  life_frame_buffer u_buf (
    .clk_i     (clk_i),
    .rst_i     (reset_i),
    .wr_en_i   (wr_en),
    .wr_quad_i (quad_q),
    .wr_data_i (valo_i),
    .rd_row_i  (row_d),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    quad_d  = quad_q;
    wait_d  = wait_q;
    row_d   = row_q;
    wr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          quad_d  = QUAD_TL;
          state_d = advance_i ? ST_STEP : ST_SELECT;
        end
      end
      ST_STEP: state_d = ST_SELECT;
      ST_SELECT: begin
        if (SAMPLE_WAIT == 0) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_WAIT;
          wait_d  = WAIT_INIT;
        end
      end
      ST_WAIT: begin
        if (wait_q == 2'd0) state_d = ST_CAPTURE;
        else                wait_d  = wait_q - 2'd1;
      end
      ST_CAPTURE: begin
        wr_en = 1'b1;
        if (quad_q == QUAD_BR) begin
          state_d = ST_EMIT;
          row_d   = 3'd0;
        end else begin
          quad_d  = quad_q + 2'd1;
          state_d = ST_SELECT;
        end
      end
      ST_EMIT: begin
        if (row_valid_q && row_ready_i) begin
          if (row_q == 3'd7) state_d = ST_DONE;
          else               row_d   = row_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      quad_q       <= QUAD_TL;
      wait_q       <= 2'd0;
      row_q        <= 3'd0;
      sel_q        <= QUAD_TL;
      step_q       <= 1'b0;
      row_data_q   <= 8'd0;
      row_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      quad_q       <= quad_d;
      wait_q       <= wait_d;
      row_q        <= row_d;
      step_q       <= (state_d == ST_STEP);
      row_valid_q  <= (state_d == ST_EMIT);
      busy_q       <= (state_d != ST_IDLE);
      frame_done_q <= (state_d == ST_DONE);
      if (state_d == ST_SELECT) sel_q      <= quad_d;
      if (state_d == ST_EMIT)   row_data_q <= rd_data;
    end
  end

  assign valo_selector_o = sel_q;
  assign step_o          = step_q;
  assign row_data_o      = row_data_q;
  assign row_index_o     = row_q;
  assign row_valid_o     = row_valid_q;
  assign busy_o          = busy_q;
  assign frame_done_o    = frame_done_q;

endmodule

// File: tb/tb_life_array_reader.sv
// Directed bench for life_array_reader with a small behavioural 8x8 life array
// (dead border) answering valo_selector and step.
module tb_life_array_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        advance;
  logic [15:0] valo;
  logic [1:0]  valo_selector;
  logic        step;
  logic [7:0]  row_data;
  logic [2:0]  row_index;
  logic        row_valid;
  logic        row_ready;
  logic        busy;
  logic        frame_done;

  life_array_reader #(.SAMPLE_WAIT(1)) u_dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .start_i         (start),
    .advance_i       (advance),
    .valo_i          (valo),
    .valo_selector_o (valo_selector),
    .step_o          (step),
    .row_data_o      (row_data),
    .row_index_o     (row_index),
    .row_valid_o     (row_valid),
    .row_ready_i     (row_ready),
    .busy_o          (busy),
    .frame_done_o    (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Array model: cell (r,c) lives in cells[8*r+c].
  logic [63:0] cells;
  logic        load;
  logic [63:0] load_val;

  function automatic logic [63:0] life_next(input logic [63:0] cur);
    logic [63:0] nxt;
    int n;
    nxt = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                (c + dc) >= 0 && (c + dc) < 8 && cur[8*(r+dr)+(c+dc)])
              n++;
          end
        end
        nxt[8*r+c] = cur[8*r+c] ? (n == 2 || n == 3) : (n == 3);
      end
    end
    return nxt;
  endfunction

  always @(posedge clk) begin
    if (load)      cells <= load_val;
    else if (step) cells <= life_next(cells);
  end

  always_comb begin
    valo = '0;
    for (int lr = 0; lr < 4; lr++) begin
      for (int lc = 0; lc < 4; lc++) begin
        valo[4*lc+lr] = cells[8*(4*int'(valo_selector[0]) + lr) + 4*int'(valo_selector[1]) + lc];
      end
    end
  end

  // Event monitor: step pulses, frame_done pulses, selector change history.
  logic       cnt_clr;
  int         step_cnt;
  int         done_cnt;
  logic [7:0] sel_seq;
  logic [1:0] sel_prev;

  always @(posedge clk) begin
    if (cnt_clr) begin
      step_cnt <= 0;
      done_cnt <= 0;
      sel_seq  <= '0;
    end else begin
      if (step)       step_cnt <= step_cnt + 1;
      if (frame_done) done_cnt <= done_cnt + 1;
      if (valo_selector != sel_prev) sel_seq <= {sel_seq[5:0], valo_selector};
    end
    sel_prev <= valo_selector;
  end

  task automatic prep(input logic [63:0] init);
    load_val = init;
    load     = 1'b1;
    cnt_clr  = 1'b1;
    @(posedge clk); #1;
    load    = 1'b0;
    cnt_clr = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready toggles, with a 5-cycle stall on row 2.
  task automatic run_frame(input string tag, input logic [63:0] init, input logic adv,
                           input logic [63:0] exp, input int mode);
    int lat, beats, cyc, stall;
    logic tog;
    logic [7:0] hold_d, obs_d;
    logic [2:0] hold_i, obs_i;
    logic obs_v;
    prep(init);
    start   = 1'b1;
    advance = adv;
    @(posedge clk); #1;
    start   = 1'b0;
    advance = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!row_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, adv ? 32'd13 : 32'd12);
    beats = 0; cyc = 0; stall = 0; tog = 1'b1;
    hold_d = '0; hold_i = '0;
    while (beats < 8 && cyc < 200) begin
      if (mode == 1 && row_valid && row_index == 3'd2 && stall < 5) begin
        if (stall == 0) begin
          hold_d = row_data;
          hold_i = row_index;
        end else begin
          check({tag, "_stall_data"}, 32'(row_data), 32'(hold_d));
          check({tag, "_stall_index"}, 32'(row_index), 32'(hold_i));
        end
        stall++;
        row_ready = 1'b0;
      end else if (mode == 1) begin
        row_ready = tog;
        tog = ~tog;
      end else begin
        row_ready = 1'b1;
      end
      obs_d = row_data;
      obs_i = row_index;
      obs_v = row_valid;
      @(posedge clk); #1;
      cyc++;
      if (obs_v && row_ready) begin
        check({tag, "_row_index"}, 32'(obs_i), beats);
        check({tag, "_row_data"}, 32'(obs_d), 32'(exp[8*beats +: 8]));
        beats++;
      end
    end
    row_ready = 1'b0;
    check({tag, "_beats"}, beats, 32'd8);
    if (mode == 0) check({tag, "_beat_cycles"}, cyc, 32'd8);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd1);
    check({tag, "_valid_after"}, 32'(row_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 32'(frame_done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_done_count"}, done_cnt, 32'd1);
    check({tag, "_step_count"}, step_cnt, adv ? 32'd1 : 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1; start = 1'b0; advance = 1'b0; row_ready = 1'b0;
    load = 1'b0; load_val = '0; cnt_clr = 1'b1;
    #1;
    check("rst_sel",   32'(valo_selector), 32'd0);
    check("rst_step",  32'(step),          32'd0);
    check("rst_valid", 32'(row_valid),     32'd0);
    check("rst_data",  32'(row_data),      32'd0);
    check("rst_index", 32'(row_index),     32'd0);
    check("rst_busy",  32'(busy),          32'd0);
    check("rst_done",  32'(frame_done),    32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    cnt_clr = 1'b0;

    run_frame("single_noadv", 64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0000_0001, 0);
    run_frame("block_adv",    64'h0000_0018_1800_0000, 1'b1, 64'h0000_0018_1800_0000, 0);
    run_frame("single_dies",  64'h0000_0400_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 0);
    run_frame("corners",      64'h8100_0000_0000_0081, 1'b0, 64'h8100_0000_0000_0081, 0);
    check("corners_q_tl", 32'(u_dut.u_buf.quad_q[0]), 32'h0001);
    check("corners_q_bl", 32'(u_dut.u_buf.quad_q[1]), 32'h0008);
    check("corners_q_tr", 32'(u_dut.u_buf.quad_q[2]), 32'h1000);
    check("corners_q_br", 32'(u_dut.u_buf.quad_q[3]), 32'h8000);
    check("corners_sel_order", 32'(sel_seq), 32'h1B);
    run_frame("diag_backpressure", 64'h8040_2010_0804_0201, 1'b0, 64'h8040_2010_0804_0201, 1);

    // Reset while capturing quadrant 2.
    prep(64'h8100_0000_0000_0081);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (valo_selector != 2'b10 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("rst_mid_reach_q2", 32'(valo_selector), 32'h2);
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_busy",  32'(busy),          32'd0);
    check("rst_mid_sel",   32'(valo_selector), 32'd0);
    check("rst_mid_valid", 32'(row_valid),     32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid_no_done", done_cnt, 32'd0);
    check("rst_mid_idle",    32'(busy), 32'd0);
    run_frame("after_reset", 64'h8040_2010_0804_0201, 1'b0, 64'h8040_2010_0804_0201, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
